// File: rtl/mux_gate_seq.sv
// Bit-serial logic unit: one shared 2x1 mux cell evaluates AND/OR/NOR/XOR a bit per clock.
// Latency WIDTH edges from accept to out_valid; a held result stalls the unit until out_ready.

module gate_mux2 (
  input  logic sel,
  input  logic i0,
  input  logic i1,
  output logic o
);
  assign o = sel ? i1 : i0;
endmodule

module mux_gate_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOR = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bit_sel;
  logic bit_b;
  logic mux_i0;
  logic mux_i1;
  logic mux_o;

  // The operand-A bit steers the shared mux; the gate type only shapes its data inputs.
  always_comb begin
    bit_sel = a_q[cnt_q];
    bit_b   = b_q[cnt_q];
    mux_i0  = 1'b0;
    mux_i1  = 1'b0;
    case (op_q)
      OP_AND: begin mux_i1 = bit_b;  mux_i0 = 1'b0;   end
      OP_OR:  begin mux_i1 = 1'b1;   mux_i0 = bit_b;  end
      OP_NOR: begin mux_i1 = 1'b0;   mux_i0 = ~bit_b; end
      OP_XOR: begin mux_i1 = ~bit_b; mux_i0 = bit_b;  end
      default: begin mux_i1 = 1'b0;  mux_i0 = 1'b0;   end
    endcase
  end

  gate_mux2 u_cell (
    .sel (bit_sel),
    .i0  (mux_i0),
    .i1  (mux_i1),
    .o   (mux_o)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[cnt_q] = mux_o;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          y_d     = res_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;

endmodule
